// File: rtl/grid_mover.sv
// grid_mover: moves a one-cell block around a 32 px grid in response to four
// buttons. Position and colour change only on vertical-blank entry. A held
// direction repeats after a delay and then at a fixed rate.
// Optional feature: define GRID_MOVER_COLOR_CYCLE_EN to advance the block
// colour through an 8-entry palette on every step. Without it, the colour is
// fixed at COLOR_DEFAULT.
module grid_mover #(
    parameter int          X_MAX         = 19,
    parameter int          Y_MAX         = 14,
    parameter int          REPEAT_DELAY  = 30,
    parameter int          REPEAT_RATE   = 6,
    parameter logic [7:0]  COLOR_DEFAULT = 8'hE0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [10:0] vcount,
    output logic [4:0]  x,
    output logic [3:0]  y,
    output logic [7:0]  color,
    output logic        moved
);

    typedef enum logic [1:0] {IDLE, FIRST, DELAY, REPEAT} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [5:0] DELAY_LOAD = 6'(REPEAT_DELAY);
    localparam logic [5:0] RATE_LOAD  = 6'(REPEAT_RATE);
    localparam logic [4:0] X_LAST     = 5'(X_MAX);
    localparam logic [3:0] Y_LAST     = 4'(Y_MAX);

    state_t      state_q, state_d;
    dir_t        dir_q, dir_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic        moved_q, moved_d;
    logic        vb_q, vb_d;

    logic        vb_match;
    logic        frame_stb;
    logic        any_btn;
    dir_t        sel_dir;
    logic        step;

    // Column after one step in direction d, wrapping at both edges.
    function automatic logic [4:0] next_x(input logic [4:0] cur, input dir_t d);
        logic [4:0] r;
        r = cur;
        if (d == DIR_RIGHT) r = (cur >= X_LAST) ? 5'd0 : cur + 5'd1;
        else if (d == DIR_LEFT) r = (cur == 5'd0) ? X_LAST : cur - 5'd1;
        return r;
    endfunction

    // Row after one step in direction d, wrapping at both edges.
    function automatic logic [3:0] next_y(input logic [3:0] cur, input dir_t d);
        logic [3:0] r;
        r = cur;
        if (d == DIR_DOWN) r = (cur >= Y_LAST) ? 4'd0 : cur + 4'd1;
        else if (d == DIR_UP) r = (cur == 4'd0) ? Y_LAST : cur - 4'd1;
        return r;
    endfunction

`ifdef GRID_MOVER_COLOR_CYCLE_EN
    logic [2:0] pal_q, pal_d;

    // Palette lookup, index 0 is the post-reset colour.
    function automatic logic [7:0] palette(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = 8'hE0;
            3'd1:    c = 8'hFC;
            3'd2:    c = 8'h1C;
            3'd3:    c = 8'h1F;
            3'd4:    c = 8'h03;
            3'd5:    c = 8'hE3;
            3'd6:    c = 8'hFF;
            default: c = 8'h92;
        endcase
        return c;
    endfunction

    // Advance the palette index once per step; the 3-bit index wraps naturally.
    always_comb begin
        pal_d = pal_q;
        if (step) pal_d = pal_q + 3'd1;
    end

    assign color = palette(pal_q);
`else
    assign color = COLOR_DEFAULT;
`endif

    // Frame strobe: first clk of vcount == 480 (vertical-blank entry).
    always_comb begin
        vb_match  = (vcount == 11'd480);
        vb_d      = vb_match;
        frame_stb = vb_match & ~vb_q;
    end

    // Direction select with fixed priority up > down > left > right.
    always_comb begin
        any_btn = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)        sel_dir = DIR_UP;
        else if (btn_down) sel_dir = DIR_DOWN;
        else if (btn_left) sel_dir = DIR_LEFT;
        else               sel_dir = DIR_RIGHT;
    end

    // Hold/repeat FSM next state; steps are only taken on a frame strobe.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_btn) begin
                    state_d = FIRST;
                    dir_d   = sel_dir;
                end
            end
            FIRST: begin
                if (!any_btn) begin
                    state_d = IDLE;
                end else begin
                    dir_d = sel_dir;
                    if (frame_stb) begin
                        step    = 1'b1;
                        cnt_d   = DELAY_LOAD;
                        state_d = DELAY;
                    end
                end
            end
            default: begin
                if (!any_btn) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end else if (sel_dir != dir_q) begin
                    // A new direction restarts the press sequence.
                    state_d = FIRST;
                    dir_d   = sel_dir;
                    cnt_d   = 6'd0;
                end else if (frame_stb) begin
                    if (cnt_q == 6'd1) begin
                        step    = 1'b1;
                        cnt_d   = RATE_LOAD;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
        endcase
    end

    // Position update and step pulse.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        moved_d = step;
        if (step) begin
            x_d = next_x(x_q, sel_dir);
            y_d = next_y(y_q, sel_dir);
        end
    end

    // All state registers; reset puts the block at the origin in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            cnt_q   <= 6'd0;
            x_q     <= 5'd0;
            y_q     <= 4'd0;
            moved_q <= 1'b0;
            vb_q    <= 1'b0;
`ifdef GRID_MOVER_COLOR_CYCLE_EN
            pal_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            moved_q <= moved_d;
            vb_q    <= vb_d;
`ifdef GRID_MOVER_COLOR_CYCLE_EN
            pal_q   <= pal_d;
`endif
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign moved = moved_q;

endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: directed scenarios plus a randomized button run, checked
// against a frame-level model of the press/delay/repeat behaviour.
module tb_grid_mover;

    localparam int X_MAX = 19;
    localparam int Y_MAX = 14;
    localparam int RD    = 30;
    localparam int RR    = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [10:0] vcount = 11'd0;
    logic [4:0]  x;
    logic [3:0]  y;
    logic [7:0]  color;
    logic        moved;

    int checks = 0;
    int errors = 0;

    // model state
    int m_x, m_y, m_ci, m_prev, m_n;
    int exp_moved_total;
    int moved_total = 0;
    int px = 0, py = 0;

    grid_mover dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .vcount(vcount), .x(x), .y(y), .color(color), .moved(moved)
    );

    always #5 clk = ~clk;

    // moved pulse counter; each high cycle must coincide with a position change
    always @(negedge clk) begin
        if (moved === 1'b1) begin
            moved_total = moved_total + 1;
            checks = checks + 1;
            if (x === 5'(px) && y === 4'(py)) begin
                errors = errors + 1;
                $display("FAIL moved_without_step got x=%0d y=%0d unchanged, expected a change", x, y);
            end
        end
        px = int'(x);
        py = int'(y);
    end

    function automatic logic [7:0] exp_color(input int ci);
`ifdef GRID_MOVER_COLOR_CYCLE_EN
        logic [7:0] pal [8];
        pal = '{8'hE0, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'hE3, 8'hFF, 8'h92};
        return pal[ci % 8];
`else
        return 8'hE0;
`endif
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_ci = 0; m_prev = -1; m_n = 0;
    endtask

    // One frame of model behaviour; b = {up, down, left, right} held all frame.
    task automatic model_frame(input logic [3:0] b);
        int d;
        bit stp;
        d = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : b[0] ? 3 : -1;
        if (d < 0) m_n = 0;
        else if (d == m_prev) m_n = m_n + 1;
        else m_n = 1;
        m_prev = d;
        stp = (d >= 0) && (m_n == 1 || (m_n > RD && ((m_n - 1 - RD) % RR) == 0));
        if (stp) begin
            case (d)
                0: m_y = (m_y == 0) ? Y_MAX : m_y - 1;
                1: m_y = (m_y == Y_MAX) ? 0 : m_y + 1;
                2: m_x = (m_x == 0) ? X_MAX : m_x - 1;
                default: m_x = (m_x == X_MAX) ? 0 : m_x + 1;
            endcase
            m_ci = m_ci + 1;
            exp_moved_total = exp_moved_total + 1;
        end
    endtask

    // Drive one frame (buttons, then vertical-blank entry held several clks) and check.
    task automatic do_frame(input logic [3:0] b, input string tag);
        {btn_up, btn_down, btn_left, btn_right} = b;
        repeat (3) @(negedge clk);
        vcount = 11'd480;
        repeat (3) @(negedge clk);
        vcount = 11'd481;
        @(negedge clk);
        vcount = 11'd0;
        @(negedge clk);
        if (rst) model_reset();
        else model_frame(b);
        checks = checks + 4;
        if (x !== 5'(m_x)) begin
            errors = errors + 1;
            $display("FAIL %s_x got %0d expected %0d", tag, x, m_x);
        end
        if (y !== 4'(m_y)) begin
            errors = errors + 1;
            $display("FAIL %s_y got %0d expected %0d", tag, y, m_y);
        end
        if (color !== exp_color(m_ci)) begin
            errors = errors + 1;
            $display("FAIL %s_color got %h expected %h", tag, color, exp_color(m_ci));
        end
        if (moved_total != exp_moved_total) begin
            errors = errors + 1;
            $display("FAIL %s_moved_count got %0d expected %0d", tag, moved_total, exp_moved_total);
            exp_moved_total = moved_total;
        end
    endtask

    task automatic apply_reset();
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks = checks + 4;
        if (x !== 5'd0) begin errors++; $display("FAIL reset_x got %0d expected 0", x); end
        if (y !== 4'd0) begin errors++; $display("FAIL reset_y got %0d expected 0", y); end
        if (color !== 8'hE0) begin errors++; $display("FAIL reset_color got %h expected e0", color); end
        if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved got %b expected 0", moved); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single_step();
        do_frame(4'b0001, "single_right");
        checks = checks + 2;
        if (x !== 5'd1 || y !== 4'd0) begin
            errors++; $display("FAIL single_step got x=%0d y=%0d expected x=1 y=0", x, y);
        end
        if (moved_total != 1) begin
            errors++; $display("FAIL single_moved got %0d pulses expected 1", moved_total);
        end
        do_frame(4'b0000, "release");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 18; i++) begin
            do_frame(4'b0001, "walk_right");
            do_frame(4'b0000, "release");
        end
        do_frame(4'b0001, "wrap_right");
        checks = checks + 1;
        if (x !== 5'd0) begin errors++; $display("FAIL wrap_right got %0d expected 0", x); end
        do_frame(4'b0000, "release");
        do_frame(4'b1000, "wrap_up");
        checks = checks + 1;
        if (y !== 4'd14) begin errors++; $display("FAIL wrap_up got %0d expected 14", y); end
        do_frame(4'b0000, "release");
    endtask

    task automatic test_priority();
        do_frame(4'b1010, "prio_up_left");
        checks = checks + 1;
        if (y !== 4'd13 || x !== 5'd0) begin
            errors++; $display("FAIL priority got x=%0d y=%0d expected x=0 y=13", x, y);
        end
        do_frame(4'b0000, "release");
    endtask

    task automatic test_hold_repeat();
        int base;
        apply_reset();
        base = moved_total;
        exp_moved_total = moved_total;
        for (int i = 0; i < 50; i++) do_frame(4'b0100, "hold_down");
        checks = checks + 2;
        if (y !== 4'd5) begin errors++; $display("FAIL hold_down_y got %0d expected 5", y); end
        if (moved_total - base != 5) begin
            errors++; $display("FAIL hold_down_steps got %0d expected 5", moved_total - base);
        end
        do_frame(4'b0000, "release");
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        exp_moved_total = moved_total;
        for (int i = 0; i < 19; i++) do_frame(4'b0010, "hold_left");
        #2 rst = 1'b1;
        #1;
        checks = checks + 1;
        if (x !== 5'd0 || y !== 4'd0) begin
            errors++; $display("FAIL async_reset got x=%0d y=%0d expected 0 0", x, y);
        end
        model_reset();
        do_frame(4'b0010, "in_reset");
        do_frame(4'b0010, "in_reset");
        rst = 1'b0;
        do_frame(4'b0010, "after_reset");
        checks = checks + 1;
        if (x !== 5'd19) begin errors++; $display("FAIL after_reset_x got %0d expected 19", x); end
        do_frame(4'b0000, "release");
    endtask

    task automatic test_color();
        logic [7:0] seq [9];
`ifdef GRID_MOVER_COLOR_CYCLE_EN
        seq = '{8'hFC, 8'h1C, 8'h1F, 8'h03, 8'hE3, 8'hFF, 8'h92, 8'hE0, 8'hFC};
`else
        seq = '{8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0};
`endif
        apply_reset();
        exp_moved_total = moved_total;
        for (int i = 0; i < 9; i++) begin
            do_frame(4'b0001, "color_press");
            checks = checks + 1;
            if (color !== seq[i]) begin
                errors++; $display("FAIL color_seq%0d got %h expected %h", i, color, seq[i]);
            end
            do_frame(4'b0000, "release");
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        b = 4'b0000;
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                b = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) b = 4'b0000;
            end
            do_frame(b, "random");
        end
    endtask

    initial begin
        exp_moved_total = 0;
        model_reset();
        test_reset();
        test_single_step();
        test_wrap();
        test_priority();
        test_hold_repeat();
        test_reset_mid_hold();
        test_color();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
